// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and default sizing for the shared-register arbiter.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module shared_reg_arbiter_rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] idx;

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + PW'(i);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester per cycle write access to a shared register,
// with an optional bounded lock that lets the current owner keep the grant.
//
//   state | meaning
//   IDLE  | no grant; q, owner and ptr hold their values
//   OWNED | exactly one grant bit set; owner wrote q at the last edge
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t        state;
    logic [PW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] winner;
    logic          any_req;
    logic          stay;

    logic [WIDTH-1:0] wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
    end

    shared_reg_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign stay = req[owner] && lock[owner] && (hold_cnt < HOLD_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            q        <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= OWNED;
                        grant    <= ONE_HOT_0 << winner;
                        owner    <= winner;
                        q        <= wdata_arr[winner];
                        hold_cnt <= HW'(1);
                        ptr      <= winner + 1'b1;
                    end
                end
                OWNED: begin
                    if (stay) begin
                        q        <= wdata_arr[owner];
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (any_req) begin
                        // ptr already points past the old owner, so it ranks last here.
                        grant    <= ONE_HOT_0 << winner;
                        owner    <= winner;
                        q        <= wdata_arr[winner];
                        hold_cnt <= HW'(1);
                        ptr      <= winner + 1'b1;
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;
    localparam int FAIR_BOUND = (N - 1) * MH + 1;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic [W-1:0]   q;
    logic [W-1:0]   qbar;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit       m_owned;
    int       m_owner;
    int       m_ptr;
    int       m_hold;
    logic [W-1:0] m_q;

    shared_reg_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .grant (grant),
        .owner (owner),
        .q     (q),
        .qbar  (qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] wd(int i);
        return wdata[i*W +: W];
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owned) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_q     = '0;
    endtask

    task automatic model_edge();
        int  w;
        bit  found;
        if (!rst) return;
        if (m_owned && req[m_owner] && lock[m_owner] && m_hold < MH) begin
            m_q    = wd(m_owner);
            m_hold = m_hold + 1;
        end else begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_owned = 1'b1;
                m_owner = w;
                m_q     = wd(w);
                m_hold  = 1;
                m_ptr   = (w + 1) % N;
            end else begin
                m_owned = 1'b0;
                m_hold  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        lock = '0;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (grant !== 4'b0000 || q !== 8'h00 || qbar !== 8'hFF || owner !== 2'd0) begin
            fails++;
            $display("FAIL reset_async: grant=%b q=%h qbar=%h owner=%0d, want 0000/00/ff/0", grant, q, qbar, owner);
        end
        tick();
        tests++;
        if (grant !== 4'b0000 || q !== 8'h00) begin
            fails++;
            $display("FAIL reset_edge_no_write: grant=%b q=%h, want 0000/00", grant, q);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (grant !== 4'b0001 || q !== 8'h10 || owner !== 2'd0) begin
            fails++;
            $display("FAIL reset_first_grant: grant=%b q=%h owner=%0d, want 0001/10/0", grant, q, owner);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] eg;
        do_reset();
        req  = 4'b1111;
        lock = '0;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + 8'(i);
        for (int k = 0; k < 8; k++) begin
            tick();
            eg = '0;
            eg[k % N] = 1'b1;
            tests++;
            if (grant !== eg || q !== 8'h10 + 8'(k % N) || q !== m_q) begin
                fails++;
                $display("FAIL rotation[%0d]: grant=%b q=%h, want %b/%h", k, grant, q, eg, 8'h10 + 8'(k % N));
            end
        end
    endtask

    task automatic test_lock_cap();
        logic [N-1:0] exp_g [10];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                  4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        wdata[0 +: W] = 8'h20;
        wdata[W +: W] = 8'h21;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++;
            if (grant !== exp_g[k] || grant !== m_grant()) begin
                fails++;
                $display("FAIL lock_cap[%0d]: grant=%b, want %b", k, grant, exp_g[k]);
            end
        end
    endtask

    task automatic test_idle_hold();
        do_reset();
        req  = 4'b0100;
        lock = '0;
        wdata[2*W +: W] = 8'hA5;
        tick();
        tests++;
        if (grant !== 4'b0100 || q !== 8'hA5) begin
            fails++;
            $display("FAIL idle_write: grant=%b q=%h, want 0100/a5", grant, q);
        end
        req = '0;
        for (int k = 0; k < 10; k++) begin
            wdata = $urandom;
            lock  = 4'($urandom);
            tick();
            tests++;
            if (grant !== 4'b0000 || q !== 8'hA5 || qbar !== 8'h5A || owner !== 2'd2) begin
                fails++;
                $display("FAIL idle_hold[%0d]: grant=%b q=%h qbar=%h owner=%0d, want 0000/a5/5a/2",
                         k, grant, q, qbar, owner);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        wdata[3*W +: W] = 8'h33;
        tick();
        tick();
        tests++;
        if (grant !== 4'b1000 || q !== 8'h33) begin
            fails++;
            $display("FAIL mid_reset_setup: grant=%b q=%h, want 1000/33", grant, q);
        end
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (grant !== 4'b0000 || q !== 8'h00 || qbar !== 8'hFF) begin
            fails++;
            $display("FAIL mid_reset_abort: grant=%b q=%h qbar=%h, want 0000/00/ff", grant, q, qbar);
        end
        req  = 4'b0110;
        lock = '0;
        wdata[W +: W] = 8'h5C;
        #2;
        rst = 1'b1;
        tick();
        tests++;
        if (grant !== 4'b0010 || q !== 8'h5C || owner !== 2'd1) begin
            fails++;
            $display("FAIL mid_reset_regrant: grant=%b q=%h owner=%0d, want 0010/5c/1", grant, q, owner);
        end
    endtask

    task automatic test_random();
        int wait_cnt [N];
        do_reset();
        req  = 4'($urandom);
        lock = 4'($urandom);
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            wdata = $urandom;
            tick();
            tests++;
            if (grant !== m_grant() || q !== m_q || owner !== 2'(m_owner)) begin
                fails++;
                $display("FAIL random_model[%0d]: grant=%b q=%h owner=%0d, want %b/%h/%0d",
                         c, grant, q, owner, m_grant(), m_q, m_owner);
            end
            tests++;
            if ((grant & (grant - 1'b1)) !== 4'b0000 || qbar !== ~q) begin
                fails++;
                $display("FAIL random_invariant[%0d]: grant=%b q=%h qbar=%h", c, grant, q, qbar);
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                tests++;
                if (wait_cnt[i] > FAIR_BOUND) begin
                    fails++;
                    $display("FAIL random_fairness[%0d] req%0d: waited %0d, limit %0d", c, i, wait_cnt[i], FAIR_BOUND);
                end
            end
            // Slow-moving req so lock runs and long waits actually occur.
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) lock[i] = ~lock[i];
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_lock_cap();
        test_idle_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (power of two, 2..8).
REQ-002 Parameter WIDTH, default 8, shared register data width.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive cycles one locked owner may keep the grant (>=1).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk.
REQ-006 req  input  N_REQ  per-requester write request, level-sensitive.
REQ-007 lock  input  N_REQ  per-requester hold request, meaningful only with matching req bit.
REQ-008 wdata  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 grant  output  N_REQ  registered one-hot grant; all-zero when idle.
REQ-010 owner  output  clog2(N_REQ)  registered index of the current grantee; holds last value when idle.
REQ-011 q  output  WIDTH  shared register contents.
REQ-012 qbar  output  WIDTH  bitwise complement of q, combinational, always equal to ~q.

Function
REQ-013 Two states: IDLE (no grant) and OWNED (exactly one grant bit set).
REQ-014 Round-robin pointer ptr (clog2(N_REQ) bits): winner = first set req bit at or after ptr, wrapping modulo N_REQ.
REQ-015 IDLE, any req set: on the next edge go OWNED; grant=onehot(winner); owner=winner; q=wdata[winner]; hold_cnt=1; ptr=(winner+1) mod N_REQ.
REQ-016 IDLE, no req set: remain IDLE; grant=0; q, owner, ptr unchanged.
REQ-017 OWNED, owner o with req[o]=1, lock[o]=1 and hold_cnt<MAX_HOLD: stay with o; q=wdata[o]; hold_cnt+1; ptr unchanged.
REQ-018 OWNED, any other case (owner dropped req or lock, or hold_cnt=MAX_HOLD): re-arbitrate per REQ-014 and REQ-015 using the current ptr; the prior owner is therefore lowest priority.
REQ-019 OWNED re-arbitration with no req set: go IDLE; grant=0; q holds its last written value.
REQ-020 Write latency: req/wdata sampled at edge k appear on grant/q after edge k; one write per cycle maximum.
REQ-021 Unlocked requester receives exactly one grant cycle per win; a locked owner receives at most MAX_HOLD consecutive cycles.
REQ-022 Fairness: any requester holding req continuously is granted within (N_REQ-1)*MAX_HOLD+1 cycles.
REQ-023 lock without req is ignored; req changes mid-grant take effect at the next edge only.
REQ-024 grant is never multi-hot; grant[owner]=1 whenever state is OWNED.

Reset
REQ-025 rst=0 forces state=IDLE, grant=0, owner=0, q=0 (qbar all ones), ptr=0, hold_cnt=0 asynchronously.
REQ-026 Reset asserted mid-grant aborts the grant immediately; no write occurs at any edge while rst=0.
REQ-027 After rst deasserts, the first edge arbitrates from ptr=0.

Structure
REQ-028 Shared package holds the state enum (IDLE, OWNED) and default parameter constants N_REQ, WIDTH, MAX_HOLD.
REQ-029 Sub-module rr_pick: combinational round-robin winner select (inputs req and ptr; outputs winner index and any_req), instantiated once.
REQ-030 Storage for q, grant, owner, ptr, hold_cnt is flip-flops with asynchronous active-low clear; no latches.

Verification (N_REQ=4, WIDTH=8, MAX_HOLD=4)
REQ-031 Reset: rst=0 while req=4'b1111 -> grant=0, q=8'h00, qbar=8'hFF; release rst, next edge -> grant=4'b0001, q=wdata[0].
REQ-032 Rotation: req=4'b1111, lock=0, wdata[i]=8'h10+i, held for 8 edges -> grant sequence 0001,0010,0100,1000,0001,...; q=11,12,13,10... after edges 2..5.
REQ-033 Lock cap: req=4'b0011, lock=4'b0001 -> owner 0 for 4 consecutive edges, then grant=4'b0010 for one cycle, then owner 0 again.
REQ-034 Idle hold: single write of 8'hA5 by requester 2, then req=0 -> grant=0, q stays 8'hA5, qbar 8'h5A for 10 cycles.
REQ-035 Mid-grant reset: locked owner 3 at hold_cnt=2, assert rst between edges -> grant=0 and q=0 before the next edge; first post-reset grant goes to lowest set req from index 0.
REQ-036 Assertions every cycle: grant one-hot or zero; qbar==~q; fairness bound per REQ-022.
